shared_reg_arbiter: RTL and testbench

Round-robin arbiter that shares one WIDTH-bit change-detecting state register among NREQ requesters. Each requester presents write data under a req/gnt handshake. The arbiter commits the winner's data into the shared register only when it differs from the current value, and it counts effective changes. It sits between several control agents and the single shared state flop bank. It is the only write path to that bank.

---
 rtl/shared_reg_arbiter.sv | 114 +++++++++++
 tb/tb_shared_reg_arbiter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter that is the sole write path into one shared change-detecting register.
// Only effective changes are committed and counted; every accepted write gets a one-cycle acknowledge.
module shared_reg_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] wdata,
    output logic [NREQ-1:0]       gnt,
    output logic [WIDTH-1:0]      q,
    output logic                  changed,
    output logic [CNT_W-1:0]      change_count,
    output logic                  busy
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [PW-1:0]    r_ptr;
    logic [PW-1:0]    w_winner;
    logic [PW-1:0]    w_ptr_next;
    logic             w_any;
    logic             w_grant;
    logic [NREQ-1:0]  r_gnt;
    logic [WIDTH-1:0] r_q;
    logic             r_changed;
    logic [CNT_W-1:0] r_count;
    logic [WIDTH-1:0] w_wdata_arr [NREQ];
    logic [WIDTH-1:0] w_wdata_win;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
            assign w_wdata_arr[gi] = wdata[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // Scan from the lowest priority upward so the last hit is the highest-priority requester.
    always_comb begin
        logic [PW:0] idx;
        w_any    = 1'b0;
        w_winner = '0;
        idx      = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = {1'b0, r_ptr} + (PW+1)'(k);
            if (idx >= (PW+1)'(NREQ)) begin
                idx = idx - (PW+1)'(NREQ);
            end
            if (req[idx[PW-1:0]]) begin
                w_any    = 1'b1;
                w_winner = idx[PW-1:0];
            end
        end
    end

    assign w_ptr_next  = (w_winner == PW'(NREQ - 1)) ? '0 : w_winner + 1'b1;
    assign w_wdata_win = w_wdata_arr[w_winner];

    always_comb begin
        w_state_next = r_state;
        w_grant      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_state_next = ACK;
                    w_grant      = 1'b1;
                end
            end
            ACK:     w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Asynchronous reset also discards a write committed at the preceding grant edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_ptr     <= '0;
            r_gnt     <= '0;
            r_q       <= '0;
            r_changed <= 1'b0;
            r_count   <= '0;
        end else begin
            r_state   <= w_state_next;
            r_gnt     <= '0;
            r_changed <= 1'b0;
            if (w_grant) begin
                r_gnt <= NREQ'(1) << w_winner;
                r_ptr <= w_ptr_next;
                if (w_wdata_win != r_q) begin
                    r_q       <= w_wdata_win;
                    r_changed <= 1'b1;
                    if (r_count != '1) begin
                        r_count <= r_count + 1'b1;
                    end
                end
            end
        end
    end

    assign gnt          = r_gnt;
    assign q            = r_q;
    assign changed      = r_changed;
    assign change_count = r_count;
    assign busy         = (r_state == ACK);

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Bench for shared_reg_arbiter: directed scenarios plus randomized traffic checked against
// a queue-free behavioural model of round-robin selection and change counting.
module tb_shared_reg_arbiter;
    localparam int NREQ  = 4;
    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] wdata;
    logic [NREQ-1:0]       gnt;
    logic [WIDTH-1:0]      q;
    logic                  changed;
    logic [CNT_W-1:0]      change_count;
    logic                  busy;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int               m_ptr;
    logic [WIDTH-1:0] m_q;
    int               m_cnt;
    logic [NREQ-1:0]  m_gnt;
    logic             m_changed;
    bit               m_ack;

    shared_reg_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .wdata        (wdata),
        .gnt          (gnt),
        .q            (q),
        .changed      (changed),
        .change_count (change_count),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_ptr     = 0;
        m_q       = '0;
        m_cnt     = 0;
        m_gnt     = '0;
        m_changed = 1'b0;
        m_ack     = 1'b0;
    endtask

    // One clock edge as the specification describes it: a grant is only possible if the
    // previous cycle was not itself an acknowledge cycle.
    task automatic model_edge(input logic [NREQ-1:0] r, input logic [NREQ*WIDTH-1:0] d);
        int w;
        int i;
        logic [WIDTH-1:0] v;
        w = -1;
        if (!m_ack && r != 0) begin
            for (int k = 0; k < NREQ; k++) begin
                i = (m_ptr + k) % NREQ;
                if (w < 0 && r[i]) w = i;
            end
            m_gnt     = NREQ'(1) << w;
            m_ptr     = (w + 1) % NREQ;
            v         = d[w*WIDTH +: WIDTH];
            m_changed = (v != m_q);
            if (m_changed) begin
                m_q = v;
                if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
            end
            m_ack = 1'b1;
        end else begin
            m_gnt     = '0;
            m_changed = 1'b0;
            m_ack     = 1'b0;
        end
    endtask

    task automatic tick();
        logic [NREQ-1:0]       r;
        logic [NREQ*WIDTH-1:0] d;
        r = req;
        d = wdata;
        @(posedge clk);
        #1;
        model_edge(r, d);
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        req   = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        wdata = '0;
        apply_reset();
        checks++; if (q !== 8'h00) begin errors++; $display("FAIL reset_q got %h want 00", q); end
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt got %b want 0000", gnt); end
        checks++; if (changed !== 1'b0) begin errors++; $display("FAIL reset_changed got %b want 0", changed); end
        checks++; if (change_count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d want 0", change_count); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        $display("reset: q=%h gnt=%b count=%0d", q, gnt, change_count);
    endtask

    task automatic test_single_write();
        wdata[7:0] = 8'h5A;
        req = 4'b0001;
        tick();
        req = '0;
        checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL single_gnt got %b want 0001", gnt); end
        checks++; if (q !== 8'h5A) begin errors++; $display("FAIL single_q got %h want 5a", q); end
        checks++; if (changed !== 1'b1) begin errors++; $display("FAIL single_changed got %b want 1", changed); end
        checks++; if (change_count !== 4'd1) begin errors++; $display("FAIL single_count got %0d want 1", change_count); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got %b want 1", busy); end
        $display("write: gnt=%b q=%h changed=%b count=%0d", gnt, q, changed, change_count);
        tick();
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL single_gnt_drop got %b want 0000", gnt); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_drop got %b want 0", busy); end
    endtask

    task automatic test_redundant_write();
        wdata[23:16] = 8'h5A;
        req = 4'b0100;
        tick();
        req = '0;
        checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL redundant_gnt got %b want 0100", gnt); end
        checks++; if (q !== 8'h5A) begin errors++; $display("FAIL redundant_q got %h want 5a", q); end
        checks++; if (changed !== 1'b0) begin errors++; $display("FAIL redundant_changed got %b want 0", changed); end
        checks++; if (change_count !== 4'd1) begin errors++; $display("FAIL redundant_count got %0d want 1", change_count); end
        $display("write: gnt=%b q=%h changed=%b count=%0d", gnt, q, changed, change_count);
        tick();
    endtask

    task automatic test_contention();
        apply_reset();
        wdata = {8'h44, 8'h33, 8'h22, 8'h11};
        req   = 4'b1111;
        for (int n = 0; n < NREQ; n++) begin
            tick();
            checks++;
            if (gnt !== (4'b0001 << n)) begin
                errors++;
                $display("FAIL contention_gnt%0d got %b want %b", n, gnt, 4'b0001 << n);
            end
            $display("write: gnt=%b q=%h changed=%b count=%0d", gnt, q, changed, change_count);
            req = req & ~gnt;
            tick();
            checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL contention_gap%0d got %b want 0000", n, gnt); end
        end
        checks++; if (q !== 8'h44) begin errors++; $display("FAIL contention_q got %h want 44", q); end
        checks++; if (change_count !== 4'd4) begin errors++; $display("FAIL contention_count got %0d want 4", change_count); end
    endtask

    task automatic test_rotation();
        wdata = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
        req = 4'b0010;
        tick();
        req = '0;
        checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL rotation_pre got %b want 0010", gnt); end
        tick();
        req = 4'b1001;
        tick();
        checks++; if (gnt !== 4'b1000) begin errors++; $display("FAIL rotation_first got %b want 1000", gnt); end
        $display("write: gnt=%b q=%h changed=%b count=%0d", gnt, q, changed, change_count);
        req[3] = 1'b0;
        tick();
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL rotation_gap got %b want 0000", gnt); end
        tick();
        checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL rotation_second got %b want 0001", gnt); end
        $display("write: gnt=%b q=%h changed=%b count=%0d", gnt, q, changed, change_count);
        req = '0;
        tick();
    endtask

    task automatic test_saturation();
        int want;
        apply_reset();
        for (int n = 0; n < 20; n++) begin
            wdata[7:0] = (n % 2) ? 8'h5A : 8'hA5;
            req = 4'b0001;
            tick();
            req = '0;
            want = (n + 1 > 15) ? 15 : n + 1;
            checks++; if (changed !== 1'b1) begin errors++; $display("FAIL sat_changed%0d got %b want 1", n, changed); end
            checks++; if (change_count !== 4'(want)) begin errors++; $display("FAIL sat_count%0d got %0d want %0d", n, change_count, want); end
            $display("write: n=%0d q=%h changed=%b count=%0d", n, q, changed, change_count);
            tick();
        end
    endtask

    task automatic test_reset_mid_ack();
        wdata[7:0] = 8'h77;
        req = 4'b0001;
        tick();
        checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL midack_pre got %b want 0001", gnt); end
        #1 reset = 1'b1;
        #1;
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL midack_gnt got %b want 0000", gnt); end
        checks++; if (q !== 8'h00) begin errors++; $display("FAIL midack_q got %h want 00", q); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midack_busy got %b want 0", busy); end
        checks++; if (changed !== 1'b0) begin errors++; $display("FAIL midack_changed got %b want 0", changed); end
        checks++; if (change_count !== 4'd0) begin errors++; $display("FAIL midack_count got %0d want 0", change_count); end
        $display("reset mid-ack: gnt=%b q=%h busy=%b", gnt, q, busy);
        req = '0;
        reset = 1'b0;
        model_reset();
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!req[i] && $urandom_range(0, 2) == 0) begin
                    wdata[i*WIDTH +: WIDTH] = 8'(8'h11 * $urandom_range(0, 3));
                    req[i] = 1'b1;
                end
            end
            tick();
            checks++; if (gnt !== m_gnt) begin errors++; $display("FAIL rand_gnt c=%0d got %b want %b", c, gnt, m_gnt); end
            checks++; if (q !== m_q) begin errors++; $display("FAIL rand_q c=%0d got %h want %h", c, q, m_q); end
            checks++; if (changed !== m_changed) begin errors++; $display("FAIL rand_changed c=%0d got %b want %b", c, changed, m_changed); end
            checks++; if (change_count !== 4'(m_cnt)) begin errors++; $display("FAIL rand_count c=%0d got %0d want %0d", c, change_count, m_cnt); end
            checks++; if (busy !== m_ack) begin errors++; $display("FAIL rand_busy c=%0d got %b want %b", c, busy, m_ack); end
            if (gnt != 0) $display("write: c=%0d gnt=%b q=%h changed=%b count=%0d", c, gnt, q, changed, change_count);
            req = req & ~gnt;
        end
        req = '0;
        tick();
    endtask

    initial begin
        reset = 1'b1;
        req   = '0;
        wdata = '0;
        model_reset();
        test_reset();
        test_single_write();
        test_redundant_write();
        test_contention();
        test_rotation();
        test_saturation();
        test_reset_mid_ack();
        apply_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
